// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller pair: coin codes, pricing
// constants, the output controller's state encoding and a small helper.
package vend_pkg;

   // Coin codes used on the coin-acceptor side of the controller pair
   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

   // Price of one product and the unit in which change is returned
   localparam int PRICE_UNITS  = 15;
   localparam int CHANGE_UNITS = 5;

   // Output controller states
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_MOTOR   = 3'd1;
   localparam logic [2:0] ST_HOP_REQ = 3'd2;
   localparam logic [2:0] ST_HOP_REL = 3'd3;
   localparam logic [2:0] ST_GAP     = 3'd4;
   localparam logic [2:0] ST_FAULT   = 3'd5;

   // Largest of three values, used to size the shared timer
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/vend_output_ctrl_fifo.sv
// Pending vend event queue: synchronous 1-bit-wide FIFO holding the chg flag
// of each captured vend. A push into a full queue is accepted only when a
// pop happens in the same cycle.
module vend_evt_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       din,
   output logic                       dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] mem;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

   // Entry storage; contents are only meaningful below count, so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/vend_output_ctrl.sv
// Downstream end of the vending controller: queues vend events, runs the
// product motor for a fixed pulse per vend, then pays one 5-unit coin via a
// four-phase req/ack handshake with the hopper when change is owed. All
// outputs are registered so actuator lines never glitch.
module vend_output_ctrl #(
   parameter int DEPTH        = 4,
   parameter int MOTOR_CYCLES = 8,
   parameter int ACK_TIMEOUT  = 16,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       dispense,
   input  logic                       chg5,
   input  logic                       hopper_ack,
   output logic                       motor_on,
   output logic                       hopper_req,
   output logic [$clog2(DEPTH+1)-1:0] pending,
   output logic                       busy,
   output logic                       overflow,
   output logic                       fault
);

   import vend_pkg::*;

   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(max3(MOTOR_CYCLES, ACK_TIMEOUT, GAP_CYCLES) + 1);

   logic [2:0]    state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          chg, chg_nxt;
   logic          pop;
   logic          push_ok;
   logic          fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;

   vend_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (dispense),
      .pop   (pop),
      .din   (chg5),
      .dout  (fifo_dout),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign pending   = count;
   assign push_ok   = dispense && (!fifo_full || pop);
   assign count_nxt = count + CW'(push_ok) - CW'(pop);

   // Sequencing: each phase loads the timer with its length minus one and
   // leaves when it reaches zero; the timer never decrements past zero.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      chg_nxt   = chg;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               chg_nxt   = fifo_dout;
               state_nxt = ST_MOTOR;
               timer_nxt = TW'(MOTOR_CYCLES - 1);
            end
         end
         ST_MOTOR: begin
            if (timer == '0) begin
               if (chg) begin
                  state_nxt = ST_HOP_REQ;
                  timer_nxt = TW'(ACK_TIMEOUT - 1);
               end else begin
                  state_nxt = ST_GAP;
                  timer_nxt = TW'(GAP_CYCLES - 1);
               end
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         ST_HOP_REQ: begin
            if (hopper_ack) begin
               state_nxt = ST_HOP_REL;
               timer_nxt = TW'(ACK_TIMEOUT - 1);
            end else if (timer == '0) begin
               state_nxt = ST_FAULT;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         ST_HOP_REL: begin
            if (!hopper_ack) begin
               state_nxt = ST_GAP;
               timer_nxt = TW'(GAP_CYCLES - 1);
            end else if (timer == '0) begin
               state_nxt = ST_FAULT;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         ST_GAP: begin
            if (timer == '0) state_nxt = ST_IDLE;
            else             timer_nxt = timer - TW'(1);
         end
         ST_FAULT: begin
            state_nxt = ST_FAULT;
         end
         default: begin
            state_nxt = ST_IDLE;
            timer_nxt = '0;
         end
      endcase
   end

   // State, timer and registered (Moore) outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         timer      <= '0;
         chg        <= 1'b0;
         motor_on   <= 1'b0;
         hopper_req <= 1'b0;
         busy       <= 1'b0;
         overflow   <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         chg        <= chg_nxt;
         motor_on   <= (state_nxt == ST_MOTOR);
         hopper_req <= (state_nxt == ST_HOP_REQ);
         fault      <= (state_nxt == ST_FAULT);
         busy       <= (state_nxt != ST_IDLE) || (count_nxt != '0);
         overflow   <= dispense && !push_ok;
      end
   end

endmodule

// File: tb/tb_vend_output_ctrl.sv
// Self-checking bench for vend_output_ctrl: a timestamp-based model of the
// vend service timeline is compared against the DUT every cycle, directed
// scenarios pin the model with literal expectations, then random traffic.
module tb_vend_output_ctrl;

   localparam int DEPTH        = 4;
   localparam int MOTOR_CYCLES = 8;
   localparam int ACK_TIMEOUT  = 16;
   localparam int GAP_CYCLES   = 2;
   localparam int PW           = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          dispense;
   logic          chg5;
   logic          hopper_ack;
   logic          motor_on;
   logic          hopper_req;
   logic [PW-1:0] pending;
   logic          busy;
   logic          overflow;
   logic          fault;

   vend_output_ctrl #(
      .DEPTH        (DEPTH),
      .MOTOR_CYCLES (MOTOR_CYCLES),
      .ACK_TIMEOUT  (ACK_TIMEOUT),
      .GAP_CYCLES   (GAP_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .dispense   (dispense),
      .chg5       (chg5),
      .hopper_ack (hopper_ack),
      .motor_on   (motor_on),
      .hopper_req (hopper_req),
      .pending    (pending),
      .busy       (busy),
      .overflow   (overflow),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit chk_en = 0;

   // Model: pending queue plus timestamps of the event in service
   bit mq[$];
   bit job, j_chg, faulted, e_ovf;
   int j_t0, j_req0, j_ackhi, j_acklo, j_idle;
   int e_pending;
   bit e_motor, e_req, e_busy, e_fault;

   // Hopper responder settings
   bit ack_lvl, hop_never;
   int ack_delay = 3, rel_delay = 2, req_age, hi_age;

   // Scenario statistics
   int runs, run_len, bad_len, bad_gap, off_len, max_pend, ovf_cnt;
   int req_hi_cnt, motor_cnt, req_first;
   bit prev_m;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("[TB] FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
      end
   endtask

   task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
      cmp(name, got, want);
   endtask

   task automatic check_output();
      cmp("motor_on",   32'(motor_on),   32'(e_motor));
      cmp("hopper_req", 32'(hopper_req), 32'(e_req));
      cmp("pending",    32'(pending),    32'(e_pending));
      cmp("busy",       32'(busy),       32'(e_busy));
      cmp("overflow",   32'(overflow),   32'(e_ovf));
      cmp("fault",      32'(fault),      32'(e_fault));
   endtask

   // Advance the model by one cycle with this cycle's inputs, producing the
   // outputs expected in the following cycle
   task automatic model_step(input bit r, input bit d, input bit c, input bit a);
      int n, m;
      n = cyc;
      m = cyc + 1;
      if (r) begin
         mq.delete();
         job = 0;
         faulted = 0;
         e_ovf = 0;
      end else begin
         if (!faulted) begin
            if (job && j_idle >= 0 && n >= j_idle) job = 0;
            if (!job) begin
               if (mq.size() > 0) begin
                  j_chg   = mq.pop_front();
                  job     = 1;
                  j_t0    = n + 1;
                  j_req0  = n + 1 + MOTOR_CYCLES;
                  j_ackhi = -1;
                  j_acklo = -1;
                  j_idle  = j_chg ? -1 : n + 1 + MOTOR_CYCLES + GAP_CYCLES;
               end
            end else if (j_chg) begin
               if (j_ackhi < 0) begin
                  if (n >= j_req0) begin
                     if (a) j_ackhi = n;
                     else if (n - j_req0 + 1 >= ACK_TIMEOUT) faulted = 1;
                  end
               end else if (j_acklo < 0) begin
                  if (!a) begin
                     j_acklo = n;
                     j_idle  = n + 1 + GAP_CYCLES;
                  end else if (n - j_ackhi >= ACK_TIMEOUT) begin
                     faulted = 1;
                  end
               end
            end
         end
         e_ovf = 0;
         if (d) begin
            if (mq.size() < DEPTH) mq.push_back(c);
            else                   e_ovf = 1;
         end
      end
      e_pending = mq.size();
      e_fault   = faulted;
      e_motor   = job && !faulted && m >= j_t0 && m < j_t0 + MOTOR_CYCLES;
      e_req     = job && !faulted && j_chg && j_ackhi < 0 && m >= j_req0;
      e_busy    = faulted || (mq.size() != 0) || (job && (j_idle < 0 || m < j_idle));
   endtask

   // Hopper behaviour: ack a request after ack_delay cycles, release after rel_delay
   task automatic hopper_respond();
      if (ack_lvl) begin
         hi_age++;
         if (hi_age >= rel_delay) begin
            ack_lvl = 0;
            hi_age  = 0;
         end
      end else if (hopper_req === 1'b1 && !hop_never) begin
         req_age++;
         if (req_age > ack_delay) begin
            ack_lvl = 1;
            req_age = 0;
            hi_age  = 0;
         end
      end else begin
         req_age = 0;
      end
   endtask

   task automatic update_stats();
      if (motor_on === 1'b1) begin
         motor_cnt++;
         if (!prev_m) begin
            if (runs > 0 && off_len < GAP_CYCLES) bad_gap++;
            runs++;
            run_len = 0;
         end
         run_len++;
      end else begin
         if (prev_m && run_len != MOTOR_CYCLES) bad_len++;
         off_len++;
      end
      if (prev_m && motor_on !== 1'b1) off_len = 1;
      prev_m = (motor_on === 1'b1);
      if (hopper_req === 1'b1) begin
         req_hi_cnt++;
         if (req_first < 0) req_first = cyc;
      end
      if (int'(pending) > max_pend) max_pend = int'(pending);
      if (overflow === 1'b1) ovf_cnt++;
   endtask

   task automatic clear_stats();
      runs = 0; run_len = 0; bad_len = 0; bad_gap = 0; off_len = 0;
      max_pend = 0; ovf_cnt = 0; req_hi_cnt = 0; motor_cnt = 0;
      req_first = -1; prev_m = 0;
   endtask

   // Drive one cycle of inputs, step the model, then check after the edge
   task automatic apply_stimulus(input bit r, input bit d, input bit c);
      bit a;
      if (r) begin
         ack_lvl = 0;
         req_age = 0;
         hi_age  = 0;
      end else begin
         hopper_respond();
      end
      a          = ack_lvl;
      rst        = r;
      dispense   = d;
      chg5       = c;
      hopper_ack = a;
      model_step(r, d, c, a);
      @(posedge clk);
      #1;
      cyc++;
      if (r) chk_en = 1;
      if (chk_en) check_output();
      update_stats();
   endtask

   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) apply_stimulus(0, 0, 0);
   endtask

   task automatic reset_dut(input int k);
      for (int i = 0; i < k; i++) apply_stimulus(1, 0, 0);
   endtask

   initial begin
      int t, dens;
      bit r, d, c;
      rst = 1; dispense = 0; chg5 = 0; hopper_ack = 0;
      hop_never = 0;
      clear_stats();
      @(negedge clk);

      // Plain vend, no change
      reset_dut(2);
      idle_cycles(3);
      clear_stats();
      apply_stimulus(0, 1, 0);
      check_lit("t1_pending", 32'(pending), 1);
      apply_stimulus(0, 0, 0);
      check_lit("t1_motor_first", 32'(motor_on), 1);
      idle_cycles(7);
      check_lit("t1_motor_last", 32'(motor_on), 1);
      idle_cycles(1);
      check_lit("t1_motor_off", 32'(motor_on), 0);
      idle_cycles(2);
      check_lit("t1_busy_clear", 32'(busy), 0);
      check_lit("t1_req_never", 32'(req_hi_cnt), 0);

      // Vend with change, hopper acks 3 cycles after request, releases 2 later
      ack_delay = 3; rel_delay = 2;
      reset_dut(2);
      idle_cycles(3);
      clear_stats();
      t = cyc;
      apply_stimulus(0, 1, 1);
      idle_cycles(30);
      check_lit("t2_req_first", 32'(req_first - t), 10);
      check_lit("t2_req_len", 32'(req_hi_cnt), 4);
      check_lit("t2_motor_len", 32'(motor_cnt), 8);
      check_lit("t2_fault", 32'(fault), 0);
      check_lit("t2_busy", 32'(busy), 0);

      // Six back-to-back vends into a depth-4 queue
      reset_dut(2);
      idle_cycles(3);
      clear_stats();
      for (int i = 0; i < 6; i++) apply_stimulus(0, 1, 0);
      check_lit("t3_ovf_pulse", 32'(overflow), 1);
      idle_cycles(80);
      check_lit("t3_runs", 32'(runs), 5);
      check_lit("t3_bad_len", 32'(bad_len), 0);
      check_lit("t3_bad_gap", 32'(bad_gap), 0);
      check_lit("t3_max_pend", 32'(max_pend), 4);
      check_lit("t3_ovf_cnt", 32'(ovf_cnt), 1);

      // Hopper never acks: timeout then sticky fault
      hop_never = 1;
      reset_dut(2);
      idle_cycles(3);
      clear_stats();
      apply_stimulus(0, 1, 1);
      idle_cycles(40);
      check_lit("t4_req_len", 32'(req_hi_cnt), 16);
      check_lit("t4_fault", 32'(fault), 1);
      clear_stats();
      apply_stimulus(0, 1, 0);
      check_lit("t4_pend_one", 32'(pending), 1);
      idle_cycles(20);
      check_lit("t4_pend_held", 32'(pending), 1);
      check_lit("t4_no_motor", 32'(motor_cnt), 0);
      reset_dut(1);
      check_lit("t4_fault_clr", 32'(fault), 0);
      check_lit("t4_pend_clr", 32'(pending), 0);
      hop_never = 0;

      // chg5 without dispense is ignored
      reset_dut(2);
      idle_cycles(2);
      clear_stats();
      for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1);
      check_lit("t5_pending", 32'(pending), 0);
      check_lit("t5_motor", 32'(motor_cnt), 0);
      check_lit("t5_busy", 32'(busy), 0);

      // Reset in the 4th motor cycle with one event queued
      reset_dut(2);
      idle_cycles(2);
      clear_stats();
      apply_stimulus(0, 1, 1);
      apply_stimulus(0, 1, 1);
      idle_cycles(3);
      check_lit("t6_motor_4th", 32'(motor_on), 1);
      check_lit("t6_pend_before", 32'(pending), 1);
      apply_stimulus(1, 0, 0);
      check_lit("t6_motor_rst", 32'(motor_on), 0);
      check_lit("t6_pend_rst", 32'(pending), 0);
      check_lit("t6_busy_rst", 32'(busy), 0);
      clear_stats();
      idle_cycles(30);
      check_lit("t6_no_req", 32'(req_hi_cnt), 0);
      check_lit("t6_no_motor", 32'(motor_cnt), 0);

      // Random traffic with occasional resets and misbehaving hoppers
      reset_dut(2);
      dens = 3;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) dens = $urandom_range(1, 8);
         r = ($urandom_range(0, 399) == 0);
         d = ($urandom_range(1, dens) == 1);
         c = $urandom_range(0, 1) == 1;
         if (r) begin
            ack_delay = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 6);
            rel_delay = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 4);
         end
         apply_stimulus(r, d, c);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vend_output_ctrl.md
Name: vend_output_ctrl

Overview:
- Downstream end of the vending controller's dispense/chg5 interface.
- Captures single-cycle vend events (dispense, optionally with chg5) into a small queue.
- Drains the queue one event at a time: drives the product motor for a fixed pulse, then, if change is owed, runs a four-phase req/ack handshake with the coin hopper.
- All outputs are registered (Moore) so actuator lines are glitch-free regardless of upstream Mealy timing.

Parameters:
DEPTH, 4, pending-event queue depth (>=2)
MOTOR_CYCLES, 8, cycles motor_on is held per vend (>=1)
ACK_TIMEOUT, 16, max cycles waiting on each hopper_ack edge before fault
GAP_CYCLES, 2, idle cycles enforced between consecutive vends (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
dispense  in  1  vend event pulse, one per cycle max
chg5  in  1  change-owed qualifier, valid only with dispense
hopper_ack  in  1  hopper acknowledge (four-phase)
motor_on  out  1  product motor drive
hopper_req  out  1  hopper request: eject one 5-unit coin
pending  out  $clog2(DEPTH+1)  queued events not yet started
busy  out  1  state != IDLE or pending != 0
overflow  out  1  one-cycle pulse: event dropped, queue full
fault  out  1  sticky hopper timeout flag

Behaviour:
- Reset: queue emptied, FSM to IDLE, timers cleared. motor_on, hopper_req, overflow and fault = 0; pending = 0; busy = 0. Reset dominates all inputs, including mid-handshake; hopper_ack is ignored during reset.
- Capture: cycle with dispense=1 pushes 1-bit entry {chg5}. chg5=1 with dispense=0 is ignored.
- Push is accepted if count<DEPTH, or if a pop occurs in the same cycle. Otherwise the entry is dropped and overflow=1 in the following cycle.
- Simultaneous push and pop leaves count unchanged. Queue order is FIFO.
- FSM states: IDLE, MOTOR, HOP_REQ, HOP_REL, GAP, FAULT.
  - IDLE: if count>0 and fault=0, pop head, latch chg flag, load timer, go to MOTOR.
  - MOTOR: motor_on=1 for exactly MOTOR_CYCLES cycles. Then go to HOP_REQ if chg=1, else GAP.
  - HOP_REQ: hopper_req=1 until hopper_ack=1, then go to HOP_REL. If ACK_TIMEOUT cycles pass without ack, go to FAULT.
  - HOP_REL: hopper_req=0 until hopper_ack=0, then go to GAP. The same ACK_TIMEOUT rule sends it to FAULT.
  - GAP: all actuators off for GAP_CYCLES cycles, then IDLE.
  - FAULT: motor_on=0, hopper_req=0, fault=1. Held until rst. The queue keeps accepting pushes (overflow still reported) but is not drained.
- Latency: dispense in cycle t with FSM idle and queue empty gives pending=1 in t+1 and motor_on=1 in cycles t+2 .. t+1+MOTOR_CYCLES.
- hopper_req rises the cycle after the last motor_on cycle. It falls the cycle after hopper_ack is first seen high.
- Timers are saturating down-counters sized $clog2 of the largest parameter +1. No wrap-around.
- pending reflects the registered count; it excludes the event currently in service.

Decomposition:
- Shared package vend_pkg holds:
  - coin codes COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10
  - the vend_output_ctrl state enum
  - price/change constants used by the controller pair
- Sub-module vend_evt_fifo: synchronous 1-bit-wide FIFO, parameter DEPTH, ports push/pop/din/dout/count/full/empty.
- Timers and FSM stay in vend_output_ctrl.

Test Plan:
- rst 2 cycles, dispense=1 chg5=0 at cycle 10 -> pending=1 at 11; motor_on high cycles 12..19; hopper_req never high; busy low from cycle 22.
- dispense=1 chg5=1 at cycle 10, bench acks 3 cycles after hopper_req rise and releases 2 cycles later -> motor_on 12..19; hopper_req 20..23; FSM back to IDLE after GAP; fault=0.
- Six back-to-back dispense pulses (chg5=0), idle start -> exactly five motor_on runs of 8 cycles, separated by >=2 off cycles; pending peaks at 4; overflow single pulse the cycle after the 6th dispense.
- dispense+chg5, hopper_ack held 0 -> hopper_req high exactly 16 cycles, then 0; fault=1 sticky; a further dispense raises pending to 1 and is never serviced; rst clears fault and pending.
- chg5=1 with dispense=0 for 5 cycles -> pending stays 0, no outputs change.
- rst asserted in 4th motor_on cycle with one event queued -> next cycle motor_on=0, pending=0, busy=0; no hopper_req afterwards.
